// File: rtl/mips_pkg.sv
// Shared widths and FSM encoding for the Rd-tag allocation/commit controller.
package mips_pkg;

   localparam int unsigned TAG_W = 5;
   localparam int unsigned NTAGS = 32;

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_e;

endpackage

// File: rtl/tag_prio_enc.sv
// Lowest-set-bit encoder over the free-tag bitmap, with an any-set flag.
module tag_prio_enc #(
   parameter int unsigned NTAGS = 32,
   parameter int unsigned TAG_W = 5
) (
   input  logic [NTAGS-1:0] req_i,
   output logic [TAG_W-1:0] idx_o,
   output logic             valid_o
);

   // Scan from the top down so the lowest set bit is the last to win.
   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      for (int i = int'(NTAGS) - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o   = TAG_W'(i);
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tag_commit_ctrl.sv
// Rd-tag allocator and in-order commit controller driving an external order queue.
module tag_commit_ctrl #(
   parameter int unsigned TAG_W = mips_pkg::TAG_W,
   parameter int unsigned NTAGS = mips_pkg::NTAGS
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             disp_req,
   output logic             disp_grant,
   output logic [TAG_W-1:0] disp_tag,
   output logic             oq_push,
   output logic [TAG_W-1:0] oq_wdata,
   output logic             oq_pop,
   input  logic [TAG_W-1:0] oq_head,
   input  logic             oq_full,
   input  logic             oq_empty,
   output logic             oq_flush,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic             flush_req,
   output logic             commit_valid,
   output logic [TAG_W-1:0] commit_tag,
   output logic [TAG_W:0]   free_count
);

   import mips_pkg::*;

   localparam int unsigned CNT_W = TAG_W + 1;

   state_e             state_q, state_d;
   logic [NTAGS-1:0]   free_q, free_d;
   logic [NTAGS-1:0]   done_q, done_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               cv_q, cv_d;
   logic [TAG_W-1:0]   ct_q, ct_d;
   logic [TAG_W-1:0]   enc_idx;
   logic               enc_valid;
   logic               run_ok;

   tag_prio_enc #(
      .NTAGS (NTAGS),
      .TAG_W (TAG_W)
   ) u_enc (
      .req_i   (free_q),
      .idx_o   (enc_idx),
      .valid_o (enc_valid)
   );

   // Same-cycle strobes; flush_req masks both grant and pop.
   always_comb begin
      run_ok     = (state_q == RUN) && !flush_req;
      disp_grant = disp_req && run_ok && enc_valid && !oq_full;
      disp_tag   = enc_idx;
      oq_push    = disp_grant;
      oq_wdata   = enc_idx;
      oq_pop     = run_ok && !oq_empty && done_q[oq_head];
      oq_flush   = (state_q == FLUSH);
   end

   always_comb begin
      state_d = state_q;
      free_d  = free_q;
      done_d  = done_q;
      cnt_d   = cnt_q;
      cv_d    = 1'b0;
      ct_d    = ct_q;
      case (state_q)
         INIT: state_d = RUN;
         RUN: begin
            if (flush_req) begin
               state_d = FLUSH;
               free_d  = '1;
               done_d  = '0;
               cnt_d   = CNT_W'(NTAGS);
            end else begin
               // Completions for tags not in flight are stale and dropped.
               if (cdb_valid && !free_q[cdb_tag]) begin
                  done_d[cdb_tag] = 1'b1;
               end
               if (disp_grant) begin
                  free_d[enc_idx] = 1'b0;
                  done_d[enc_idx] = 1'b0;
               end
               if (oq_pop) begin
                  free_d[oq_head] = 1'b1;
                  done_d[oq_head] = 1'b0;
                  cv_d            = 1'b1;
                  ct_d            = oq_head;
               end
               if (disp_grant && !oq_pop && (cnt_q != '0)) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else if (oq_pop && !disp_grant && (cnt_q < CNT_W'(NTAGS))) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         FLUSH: begin
            if (!flush_req) begin
               state_d = RUN;
            end
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= INIT;
         free_q  <= '1;
         done_q  <= '0;
         cnt_q   <= CNT_W'(NTAGS);
         cv_q    <= 1'b0;
         ct_q    <= '0;
      end else begin
         state_q <= state_d;
         free_q  <= free_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
         cv_q    <= cv_d;
         ct_q    <= ct_d;
      end
   end

   assign commit_valid = cv_q;
   assign commit_tag   = ct_q;
   assign free_count   = cnt_q;

endmodule

// File: doc/tag_commit_ctrl.md
TAG_COMMIT_CTRL -- requirements
Module: tag_commit_ctrl

Interface
REQ-001 The block SHALL have parameter TAG_W, default 5, Rd tag width.
REQ-002 The block SHALL have parameter NTAGS, default 32 (2**TAG_W), number of Rd tags and order queue depth.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports as below.
REQ-004 The block SHALL have port clock  in  1  single rising-edge clock.
REQ-005 The block SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-006 The block SHALL have port disp_req  in  1  dispatch requests an Rd tag.
REQ-007 The block SHALL have port disp_grant  out  1  tag allocated this cycle.
REQ-008 The block SHALL have port disp_tag  out  TAG_W  allocated tag, valid with disp_grant.
REQ-009 The block SHALL have port oq_push  out  1  order queue write strobe (new_data).
REQ-010 The block SHALL have port oq_wdata  out  TAG_W  order queue write data (inData).
REQ-011 The block SHALL have port oq_pop  out  1  order queue read strobe (out_data).
REQ-012 The block SHALL have port oq_head  in  TAG_W  order queue head tag (outData).
REQ-013 The block SHALL have port oq_full  in  1  order queue full.
REQ-014 The block SHALL have port oq_empty  in  1  order queue empty.
REQ-015 The block SHALL have port oq_flush  out  1  order queue flush.
REQ-016 The block SHALL have port cdb_valid  in  1  completion broadcast valid.
REQ-017 The block SHALL have port cdb_tag  in  TAG_W  completing tag.
REQ-018 The block SHALL have port flush_req  in  1  mispredict flush request.
REQ-019 The block SHALL have port commit_valid  out  1  registered retire strobe.
REQ-020 The block SHALL have port commit_tag  out  TAG_W  registered retired tag.
REQ-021 The block SHALL have port free_count  out  TAG_W+1  number of free tags.

Function
REQ-022 The block SHALL implement FSM states INIT, RUN, FLUSH: INIT->RUN unconditionally; RUN->FLUSH on flush_req; FLUSH->RUN when flush_req=0, otherwise stay in FLUSH.
REQ-023 The block SHALL hold free[NTAGS] and done[NTAGS] bitmaps.
REQ-024 The block SHALL drive disp_grant combinationally as disp_req && state==RUN && !flush_req && free!=0 && !oq_full.
REQ-025 The block SHALL drive disp_tag as the lowest-index set bit of free, with oq_push=disp_grant and oq_wdata=disp_tag in the same cycle.
REQ-026 On a grant, the block SHALL clear free[disp_tag] and done[disp_tag] at the clock edge.
REQ-027 On cdb_valid, the block SHALL set done[cdb_tag] at the edge, ignoring tags whose free bit is set.
REQ-028 The block SHALL drive oq_pop combinationally as state==RUN && !flush_req && !oq_empty && done[oq_head], using the registered done bit with no CDB bypass, so minimum completion-to-pop latency is 1 cycle.
REQ-029 On a pop, the block SHALL set free[oq_head] and clear done[oq_head] at the edge, and SHALL set commit_valid=1 and commit_tag=oq_head in the next cycle.
REQ-030 The block SHALL otherwise hold commit_valid=0 and commit_tag at its last value.
REQ-031 A tag freed in cycle N SHALL become allocatable in cycle N+1, never in the same cycle.
REQ-032 The block SHALL update free_count as +1 on pop, -1 on grant, unchanged when both occur, never exceeding NTAGS and never below 0.
REQ-033 The block SHALL assert oq_flush=1 only in FLUSH and SHALL hold disp_grant=0 and oq_pop=0 there.
REQ-034 On entry to FLUSH, the block SHALL set free to all-ones, clear done, and set free_count=NTAGS.
REQ-035 flush_req in RUN SHALL take priority: same-cycle grant and pop are suppressed.
REQ-036 A cdb_valid arriving during FLUSH SHALL be ignored.

Reset
REQ-037 With reset_n=0 (asynchronous), the block SHALL set state=INIT, free=all-ones, done=0, free_count=NTAGS, commit_valid=0, commit_tag=0.
REQ-038 In INIT, the block SHALL hold disp_grant, oq_push, oq_pop and oq_flush at 0.
REQ-039 A reset mid-operation SHALL abandon all outstanding tags, with no commit_valid pulse generated.

Structure
REQ-040 Shared package mips_pkg SHALL hold TAG_W, NTAGS and the INIT/RUN/FLUSH state encoding.
REQ-041 The block SHALL include one combinational sub-module tag_prio_enc (NTAGS-bit lowest-set-bit encoder with valid flag).

Verification
REQ-042 The bench SHALL cover: reset release, 3 cycles disp_req=1 -> grants tags 0,1,2 on cycles 2-4 after INIT; free_count 32->29.
REQ-043 The bench SHALL cover: cdb tag 1, then tag 0, with head=0 -> pop head 0 the cycle after tag 0's done bit registers; commit_tag 0 then 1 on consecutive cycles; tag 2 not committed.
REQ-044 The bench SHALL cover: 32 grants with no completion -> free_count=0, disp_grant=0 on the 33rd request; commit tag 0 -> next cycle grant returns tag 0.
REQ-045 The bench SHALL cover: flush_req with disp_req=1 and a committable head in the same cycle -> no grant, no pop; oq_flush=1 the next cycle; free_count=32; first post-flush grant is tag 0.
REQ-046 The bench SHALL cover: cdb_valid on a free tag 7 -> done[7] stays 0; later allocation of 7 is not committed until its own cdb.
REQ-047 The bench SHALL cover: reset_n asserted asynchronously with 5 tags outstanding -> outputs reach reset values immediately; no commit_valid after release.
